prescaled_bcd_counter: RTL and testbench
========================================

// Module: prescaled_bcd_counter
// PURPOSE
//  Multi-digit BCD counter driven by an internal clock-enable prescaler; successor of the fixed 0-9 divider/counter pair.
//  Adds run-time up/down, synchronous parallel load, a per-tick strobe and a terminal-count strobe.
//  Sits between the board clock and display/decoder logic; output feeds 7-segment drivers one nibble per digit.
// PARAMETERS
//  CLK_DIV  12500000  CLK cycles per count step (>=1); 12500000 at 50 MHz = 0.25 s
//  DIGITS   2         number of BCD digits (1..8); COUNT width = 4*DIGITS
//  DIV_W    derived   max(1,$clog2(CLK_DIV)); localparam, not overridable
// PORTS
//  CLK       in   1         system clock, all logic on rising edge
//  RST       in   1         synchronous reset, active-high
//  EN        in   1         1 = prescaler runs; 0 = prescaler and counter frozen
//  UP_DN     in   1         1 = count up, 0 = count down; sampled on each tick
//  LOAD      in   1         synchronous load of LOAD_VAL
//  LOAD_VAL  in   4*DIGITS  BCD load value, digit 0 in [3:0]
//  COUNT     out  4*DIGITS  registered BCD count, digit 0 in [3:0]
//  TICK      out  1         one-cycle strobe: count advances this cycle
//  TC        out  1         one-cycle strobe: count wraps this cycle
// BEHAVIOUR
//  Reset: COUNT=0, prescaler count=0, TICK=0, TC=0. Same-edge priority: RST > LOAD > tick.
//  Prescaler: div_cnt runs 0..CLK_DIV-1 while EN=1, then wraps to 0; held while EN=0.
//   TICK = EN & (div_cnt==CLK_DIV-1), combinational from registered div_cnt; CLK_DIV=1 -> TICK=EN.
//   First TICK after reset/load is CLK_DIV cycles after EN goes high; period CLK_DIV cycles thereafter.
//  Count step on TICK (COUNT updates on that edge):
//   up: digit0+1; a digit at 9 -> 0 and carries into the next; all-9s -> all-0s.
//   down: digit0-1; a digit at 0 -> 9 and borrows from the next; all-0s -> all-9s.
//   Digits never take values 10-15 by counting.
//  TC = TICK & (UP_DN ? COUNT==all 9s : COUNT==0); asserted in the same cycle as the wrapping TICK.
//  LOAD=1: COUNT <= LOAD_VAL with each digit >9 clamped to 9; div_cnt <= 0; TICK and TC suppressed that cycle; EN is ignored.
//  LOAD held high: COUNT tracks LOAD_VAL every cycle; counting resumes CLK_DIV cycles after release (EN=1).
//  UP_DN may change on any cycle; takes effect on the next TICK, no glitch, no lost tick.
//  RST during counting: the next edge returns all state to reset values regardless of EN or LOAD.
//  Counter state is never corrupted by EN toggling; an EN-low cycle simply stretches the period.
// CONFIGURATION
//  PRESCALER_BYPASS_EN defined: extra input BYPASS (1 bit, placed after LOAD_VAL).
//   BYPASS=1 -> TICK=EN every cycle; div_cnt held at 0; all other rules unchanged.
//   Used for fast simulation and bring-up.
//  Not defined: no BYPASS port; the prescaler is always active.
// TESTING (CLK_DIV=4, DIGITS=2 unless stated)
//  1 RST=1 for 2 cycles, then EN=1, UP_DN=1 -> COUNT=0x00; first TICK on cycle 4; COUNT=0x01 after it; TICK every 4 cycles.
//  2 Up from 0x00 for 100 ticks -> sequence 0x09 -> 0x10, 0x99 -> 0x00; TC high exactly once, on the 0x99 tick.
//  3 LOAD=1 with LOAD_VAL=0x00, UP_DN=0 -> next tick gives 0x99 with TC=1; LOAD_VAL=0xAF -> COUNT=0x99 (clamp).
//  4 EN dropped for 3 cycles at div_cnt=2 -> TICK delayed exactly 3 cycles; COUNT unchanged.
//  5 LOAD and RST asserted together mid-count -> COUNT=0x00; RST and TICK together -> COUNT=0x00, TC=0.
//  6 PRESCALER_BYPASS_EN, BYPASS=1, DIGITS=3 -> TICK every cycle; 0x999 -> 0x000 wrap with TC=1.

Source files
------------

// File: rtl/prescaled_bcd_counter.sv
// prescaled_bcd_counter
//   Multi-digit BCD up/down counter. An internal prescaler produces a
//   clock-enable (TICK) once every CLK_DIV cycles. The counter supports a
//   synchronous parallel load, and emits a terminal-count strobe (TC) on wrap.
//
// Parameters
//   CLK_DIV  CLK cycles per count step (>=1)
//   DIGITS   number of BCD digits (1..8)
//
// Ports
//   CLK       system clock, rising edge
//   RST       synchronous reset, active-high
//   EN        1 = prescaler runs, 0 = prescaler and counter frozen
//   UP_DN     1 = count up, 0 = count down (sampled on each tick)
//   LOAD      synchronous load of LOAD_VAL (digits >9 clamped to 9)
//   LOAD_VAL  BCD load value, digit 0 in [3:0]
//   BYPASS    (only with PRESCALER_BYPASS_EN) 1 = tick every EN cycle
//   COUNT     registered BCD count, digit 0 in [3:0]
//   TICK      one-cycle strobe: count advances this cycle
//   TC        one-cycle strobe: count wraps this cycle
//
// Build option
//   PRESCALER_BYPASS_EN  adds the BYPASS input

// One BCD digit of the up/down chain. cin is the carry (up) or borrow
// (down) arriving from the lower digit; digit 0 always gets cin=1.
module bcd_digit_step (
   input  logic [3:0] digit,
   input  logic       up,
   input  logic       cin,
   output logic [3:0] next,
   output logic       cout
);
   always_comb begin
      next = digit;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (digit == 4'd9) begin
               next = 4'd0;
               cout = 1'b1;
            end else begin
               next = digit + 4'd1;
            end
         end else begin
            if (digit == 4'd0) begin
               next = 4'd9;
               cout = 1'b1;
            end else begin
               next = digit - 4'd1;
            end
         end
      end
   end
endmodule

module prescaled_bcd_counter #(
   parameter int CLK_DIV = 12500000,
   parameter int DIGITS  = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  UP_DN,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
`ifdef PRESCALER_BYPASS_EN
   input  logic                  BYPASS,
`endif
   output logic [4*DIGITS-1:0]   COUNT,
   output logic                  TICK,
   output logic                  TC
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]    div_cnt;
   logic                div_end;
   logic                bypass;
   logic [DIGITS:0]     carry;
   logic [4*DIGITS-1:0] count_next;
   logic [4*DIGITS-1:0] load_clamped;

`ifdef PRESCALER_BYPASS_EN
   assign bypass = BYPASS;
`else
   assign bypass = 1'b0;
`endif

   assign div_end = (div_cnt == DIV_MAX);

   // Load and reset both own the edge, so no count step is announced then.
   assign TICK = EN & ~LOAD & ~RST & (bypass | div_end);

   // Carry out of the top digit is set exactly when every digit wraps,
   // i.e. all 9s going up or all 0s going down.
   assign carry[0] = 1'b1;
   assign TC       = TICK & carry[DIGITS];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_step u_step (
         .digit (COUNT[4*i +: 4]),
         .up    (UP_DN),
         .cin   (carry[i]),
         .next  (count_next[4*i +: 4]),
         .cout  (carry[i+1])
      );
      assign load_clamped[4*i +: 4] =
         (LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*i +: 4];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt <= '0;
         COUNT   <= '0;
      end else if (LOAD) begin
         div_cnt <= '0;
         COUNT   <= load_clamped;
      end else begin
         // In bypass the divider parks at 0 so leaving bypass restarts a full period.
         if (EN)
            div_cnt <= (bypass | div_end) ? '0 : div_cnt + DIV_W'(1);
         if (TICK)
            COUNT <= count_next;
      end
   end
endmodule

// File: tb/tb_prescaled_bcd_counter.sv
module tb_prescaled_bcd_counter;
   localparam int CLK_DIV = 4;
   localparam int DIGITS  = 2;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, load;
   logic [7:0] load_val;
   logic [7:0] count;
   logic       tick, tc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

`ifdef PRESCALER_BYPASS_EN
   logic        b_rst, b_en, b_up, b_load, b_bypass;
   logic [11:0] b_val, b_count;
   logic        b_tick, b_tc;

   prescaled_bcd_counter #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
      .CLK(clk), .RST(rst), .EN(en), .UP_DN(up_dn), .LOAD(load),
      .LOAD_VAL(load_val), .BYPASS(1'b0), .COUNT(count), .TICK(tick), .TC(tc));

   prescaled_bcd_counter #(.CLK_DIV(CLK_DIV), .DIGITS(3)) b_dut (
      .CLK(clk), .RST(b_rst), .EN(b_en), .UP_DN(b_up), .LOAD(b_load),
      .LOAD_VAL(b_val), .BYPASS(b_bypass), .COUNT(b_count), .TICK(b_tick), .TC(b_tc));
`else
   prescaled_bcd_counter #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
      .CLK(clk), .RST(rst), .EN(en), .UP_DN(up_dn), .LOAD(load),
      .LOAD_VAL(load_val), .COUNT(count), .TICK(tick), .TC(tc));
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] bcd2(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Advance until TICK is seen; n = edges taken. Timeout is a failure.
   task automatic wait_tick(output int n);
      n = 0;
      while (!tick && n < 20) begin
         step();
         n++;
      end
      if (!tick) begin
         checks++;
         errors++;
         $display("FAIL wait_tick: no TICK within %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
      step(); step();
      rst = 1'b0; en = 1'b1;
      checks++;
      if (count !== 8'h00 || tick !== 1'b0 || tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: count=%h tick=%b tc=%b want 00/0/0", count, tick, tc);
      end
      wait_tick(n);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL first_tick_latency: edges=%0d want 3", n);
      end
      step();
      checks++;
      if (count !== 8'h01 || tick !== 1'b0) begin
         errors++;
         $display("FAIL first_step: count=%h tick=%b want 01/0", count, tick);
      end
   endtask

   task automatic test_count_up();
      int n, exp_v, tc_seen;
      load = 1'b1; load_val = 8'h00;
      step();
      load = 1'b0;
      exp_v = 0; tc_seen = 0;
      for (int k = 0; k < 100; k++) begin
         wait_tick(n);
         checks++;
         if (n !== 3) begin
            errors++;
            $display("FAIL up_period k=%0d: edges=%0d want 3", k, n);
         end
         checks++;
         if (tc !== (exp_v == 99)) begin
            errors++;
            $display("FAIL up_tc k=%0d: tc=%b want %b", k, tc, exp_v == 99);
         end
         if (tc === 1'b1) tc_seen++;
         step();
         exp_v = (exp_v + 1) % 100;
         checks++;
         if (count !== bcd2(exp_v)) begin
            errors++;
            $display("FAIL up_count k=%0d: count=%h want %h", k, count, bcd2(exp_v));
         end
      end
      checks++;
      if (tc_seen !== 1) begin
         errors++;
         $display("FAIL up_tc_once: tc pulses=%0d want 1", tc_seen);
      end
   endtask

   task automatic test_load();
      int n;
      up_dn = 1'b0; load = 1'b1; load_val = 8'h00;
      step();
      checks++;
      if (count !== 8'h00 || tick !== 1'b0) begin
         errors++;
         $display("FAIL load_zero: count=%h tick=%b want 00/0", count, tick);
      end
      load = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 3 || tc !== 1'b1) begin
         errors++;
         $display("FAIL down_wrap_tc: edges=%0d tc=%b want 3/1", n, tc);
      end
      step();
      checks++;
      if (count !== 8'h99) begin
         errors++;
         $display("FAIL down_wrap: count=%h want 99", count);
      end
      load = 1'b1; load_val = 8'hAF;
      step();
      checks++;
      if (count !== 8'h99) begin
         errors++;
         $display("FAIL load_clamp: count=%h want 99", count);
      end
      load_val = 8'h35;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (count !== 8'h35 || tick !== 1'b0) begin
            errors++;
            $display("FAIL load_held i=%0d: count=%h tick=%b want 35/0", i, count, tick);
         end
      end
      load_val = 8'h10;
      step();
      load = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 3 || tc !== 1'b0) begin
         errors++;
         $display("FAIL load_release: edges=%0d tc=%b want 3/0", n, tc);
      end
      step();
      checks++;
      if (count !== 8'h09) begin
         errors++;
         $display("FAIL down_borrow: count=%h want 09", count);
      end
      up_dn = 1'b1;
      wait_tick(n);
      step();
      checks++;
      if (count !== 8'h10) begin
         errors++;
         $display("FAIL up_carry: count=%h want 10", count);
      end
   endtask

   task automatic test_en_stall();
      int n;
      load = 1'b1; load_val = 8'h20; up_dn = 1'b1;
      step();
      load = 1'b0;
      step(); step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (tick !== 1'b0 || count !== 8'h20) begin
            errors++;
            $display("FAIL en_low i=%0d: tick=%b count=%h want 0/20", i, tick, count);
         end
      end
      en = 1'b1;
      wait_tick(n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL en_stretch: edges=%0d want 1", n);
      end
      step();
      checks++;
      if (count !== 8'h21) begin
         errors++;
         $display("FAIL en_resume: count=%h want 21", count);
      end
   endtask

   task automatic test_rst_priority();
      int n;
      load = 1'b1; load_val = 8'h55; rst = 1'b1;
      step();
      load = 1'b0; rst = 1'b0;
      checks++;
      if (count !== 8'h00 || tick !== 1'b0) begin
         errors++;
         $display("FAIL rst_over_load: count=%h tick=%b want 00/0", count, tick);
      end
      up_dn = 1'b0;
      wait_tick(n);
      checks++;
      if (n !== 3 || tc !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_tick: edges=%0d tc=%b want 3/1", n, tc);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (count !== 8'h00 || tc !== 1'b0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL rst_over_tick: count=%h tc=%b tick=%b want 00/0/0", count, tc, tick);
      end
      wait_tick(n);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL post_rst_period: edges=%0d want 3", n);
      end
   endtask

`ifdef PRESCALER_BYPASS_EN
   task automatic test_bypass();
      b_rst = 1'b1;
      step();
      b_rst = 1'b0; b_bypass = 1'b1; b_en = 1'b1; b_up = 1'b1;
      b_load = 1'b1; b_val = 12'h998;
      step();
      b_load = 1'b0;
      checks++;
      if (b_tick !== 1'b1 || b_count !== 12'h998 || b_tc !== 1'b0) begin
         errors++;
         $display("FAIL byp_first: tick=%b count=%h tc=%b want 1/998/0", b_tick, b_count, b_tc);
      end
      step();
      checks++;
      if (b_tick !== 1'b1 || b_count !== 12'h999 || b_tc !== 1'b1) begin
         errors++;
         $display("FAIL byp_tc: tick=%b count=%h tc=%b want 1/999/1", b_tick, b_count, b_tc);
      end
      step();
      checks++;
      if (b_count !== 12'h000 || b_tc !== 1'b0) begin
         errors++;
         $display("FAIL byp_wrap: count=%h tc=%b want 000/0", b_count, b_tc);
      end
      b_en = 1'b0;
      #1;
      checks++;
      if (b_tick !== 1'b0) begin
         errors++;
         $display("FAIL byp_en_low: tick=%b want 0", b_tick);
      end
   endtask
`endif

   initial begin
`ifdef PRESCALER_BYPASS_EN
      b_rst = 1'b1; b_en = 1'b0; b_up = 1'b1; b_load = 1'b0;
      b_bypass = 1'b0; b_val = 12'h000;
`endif
      test_reset();
      test_count_up();
      test_load();
      test_en_stall();
      test_rst_priority();
`ifdef PRESCALER_BYPASS_EN
      test_bypass();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
